// File: rtl/exp_pkg.sv
// Shared constants and types for the exponential engine result path.
// EXP_SER_PARITY_EN appends an even-parity bit to every serial frame.
package exp_pkg;

  localparam int EXP_INT_W  = 2;
  localparam int EXP_FRAC_W = 16;
  localparam int EXP_WORD_W = EXP_INT_W + EXP_FRAC_W;

  typedef enum logic {
    IDLE,
    SHIFT
  } ser_state_t;

`ifdef EXP_SER_PARITY_EN
  localparam int EXP_PAR_W = 1;
`else
  localparam int EXP_PAR_W = 0;
`endif

  localparam int EXP_FRAME_W = EXP_WORD_W + EXP_PAR_W;

  function automatic int frame_len(input int word_w);
    return word_w + EXP_PAR_W;
  endfunction

endpackage

// File: rtl/exp_result_fifo.sv
// Circular DEPTH x W result buffer with wrapping pointers.
// Caller never pops when empty and gates pushes when full.
module exp_result_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 18
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 din,
  output logic [W-1:0]                 dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (push)
      r_mem[r_wr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (push)
        r_wr <= r_wr + 1'b1;
      if (pop)
        r_rd <= r_rd + 1'b1;
      unique case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = r_mem[r_rd];
  assign count = r_count;
  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);

endmodule

// File: rtl/exp_result_serializer.sv
// Buffers exp engine results and shifts them out MSB-first.
// EXP_SER_PARITY_EN adds a trailing even-parity bit per frame.
module exp_result_serializer
  import exp_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int INT_W  = EXP_INT_W,
  parameter int FRAC_W = EXP_FRAC_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        done_in,
  input  logic [INT_W-1:0]            intpart,
  input  logic [FRAC_W-1:0]           fracpart,
  input  logic                        ser_ready,
  input  logic                        ovf_clr,
  output logic                        ser_data,
  output logic                        ser_valid,
  output logic                        ser_first,
  output logic                        ser_last,
  output logic [$clog2(DEPTH+1)-1:0]  fifo_count,
  output logic                        fifo_full,
  output logic                        overflow
);

  localparam int WORD_W  = INT_W + FRAC_W;
  localparam int FRAME_W = frame_len(WORD_W);
  localparam int BW      = $clog2(FRAME_W);
  localparam logic [BW-1:0] LAST = BW'(FRAME_W - 1);

  ser_state_t       r_state;
  logic [FRAME_W-1:0] r_shreg;
  logic [BW-1:0]    r_bitcnt;
  logic             r_done_q;
  logic             r_ovf;

  logic [WORD_W-1:0]  w_dout;
  logic [FRAME_W-1:0] w_load;
  logic               w_full;
  logic               w_empty;
  logic               w_req;
  logic               w_xfer;
  logic               w_end;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic               w_shift;

  assign w_shift = (r_state == SHIFT);
  assign w_req   = done_in & ~r_done_q;
  assign w_xfer  = w_shift & ser_ready;
  assign w_end   = w_xfer & (r_bitcnt == LAST);
  assign w_pop   = ~w_empty & (~w_shift | w_end);
  assign w_push  = w_req & (~w_full | w_pop);
  assign w_drop  = w_req & w_full & ~w_pop;

`ifdef EXP_SER_PARITY_EN
  assign w_load = {w_dout, ^w_dout};
`else
  assign w_load = w_dout;
`endif

  exp_result_fifo #(
    .DEPTH (DEPTH),
    .W     (WORD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   ({intpart, fracpart}),
    .dout  (w_dout),
    .count (fifo_count),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_done_q <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_done_q <= done_in;
      if (w_drop)
        r_ovf <= 1'b1;
      else if (ovf_clr)
        r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_shreg  <= '0;
      r_bitcnt <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_shreg  <= w_load;
            r_bitcnt <= '0;
            r_state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_end) begin
            r_bitcnt <= '0;
            if (w_pop)
              r_shreg <= w_load;
            else
              r_state <= IDLE;
          end else if (w_xfer) begin
            r_shreg  <= r_shreg << 1;
            r_bitcnt <= r_bitcnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ser_valid = w_shift;
  assign ser_data  = w_shift & r_shreg[FRAME_W-1];
  assign ser_first = w_shift & (r_bitcnt == '0);
  assign ser_last  = w_shift & (r_bitcnt == LAST);
  assign fifo_full = w_full;
  assign overflow  = r_ovf;

endmodule
